// File: rtl/memory_writer_pkg.sv
// Shared types and widths for the frame writer: FSM state codes and bus widths.
package memory_writer_pkg;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 8;
  localparam int CNT_W  = 10;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_WRITE = 2'd1;
  localparam state_t S_DONE  = 2'd2;
endpackage

// File: rtl/memory_writer_img_pos.sv
// img_pos_counter: row/column position of the next pixel to be written.
// Column wraps at MAX_COL-1 and bumps the row; row wraps at MAX_ROW-1.
module img_pos_counter
  import memory_writer_pkg::*;
#(
  parameter int MAX_ROW = 540,
  parameter int MAX_COL = 540
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [CNT_W-1:0] row_o,
  output logic [CNT_W-1:0] col_o
);

  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      r_row <= '0;
      r_col <= '0;
    end else if (advance_i) begin
      if (r_col == CNT_W'(MAX_COL - 1)) begin
        r_col <= '0;
        if (r_row == CNT_W'(MAX_ROW - 1)) r_row <= '0;
        else                              r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign row_o = r_row;
  assign col_o = r_col;

endmodule

// File: rtl/memory_writer.sv
// Streams one frame of pixels into a BRAM port, one registered write per accepted pixel.
// Optional row-end pulse output enabled by macro MEMORY_WRITER_ROW_DONE_EN.
module memory_writer
  import memory_writer_pkg::*;
#(
  parameter int MAX_ROW = 540,
  parameter int MAX_COL = 540
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  data_i,
  input  logic              data_en_i,
  input  logic              start_i,
  output logic              ena_o,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [PIX_W-1:0]  d2mem_o,
  output logic              busy_o,
  output logic              write_done_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  cnt_img_row_o,
  output logic [CNT_W-1:0]  cnt_img_col_o
`ifdef MEMORY_WRITER_ROW_DONE_EN
  ,
  output logic              row_done_o
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ROW * MAX_COL - 1);

  if (MAX_ROW * MAX_COL > (1 << ADDR_W)) begin : g_size_check
    $error("memory_writer: MAX_ROW*MAX_COL does not fit the 19-bit address space");
  end

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_addr;
  logic [PIX_W-1:0]  r_data;
  logic              r_we;
  logic              r_done;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt_row;
  logic [CNT_W-1:0]  r_cnt_col;

  logic              w_start;
  logic              w_accept;
  logic              w_last;
  logic              w_stray;
  logic [CNT_W-1:0]  w_row;
  logic [CNT_W-1:0]  w_col;

  assign w_start  = (r_state == S_IDLE) && start_i;
  assign w_accept = (r_state == S_WRITE) && data_en_i;
  assign w_last   = w_accept && (r_wr_addr == LAST_ADDR);
  assign w_stray  = data_en_i && (r_state != S_WRITE);

  img_pos_counter #(
    .MAX_ROW (MAX_ROW),
    .MAX_COL (MAX_COL)
  ) u_pos (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (w_start),
    .advance_i (w_accept),
    .row_o     (w_row),
    .col_o     (w_col)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wr_addr <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_cnt_row <= '0;
      r_cnt_col <= '0;
    end else begin
      r_we   <= w_accept;
      r_data <= w_accept ? data_i : '0;
      r_done <= w_last;

      // Address/position outputs hold between strobes; the final pixel leaves r_wr_addr at LAST_ADDR.
      if (w_accept) begin
        r_addr    <= r_wr_addr;
        r_cnt_row <= w_row;
        r_cnt_col <= w_col;
        if (!w_last) r_wr_addr <= r_wr_addr + 1'b1;
      end
      if (w_start) r_wr_addr <= '0;

      // A pixel arriving with the start request is dropped, so it still counts as stray.
      if (w_start)      r_err <= data_en_i;
      else if (w_stray) r_err <= 1'b1;

      case (r_state)
        S_IDLE:  if (start_i) r_state <= S_WRITE;
        S_WRITE: if (w_last)  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MEMORY_WRITER_ROW_DONE_EN
  logic r_row_done;

  always_ff @(posedge clk) begin
    if (rst) r_row_done <= 1'b0;
    else     r_row_done <= w_accept && (w_col == CNT_W'(MAX_COL - 1));
  end

  assign row_done_o = r_row_done;
`endif

  assign ena_o         = r_we;
  assign wea_o         = r_we;
  assign addr_o        = r_addr;
  assign d2mem_o       = r_data;
  assign busy_o        = (r_state == S_WRITE);
  assign write_done_o  = r_done;
  assign err_o         = r_err;
  assign cnt_img_row_o = r_cnt_row;
  assign cnt_img_col_o = r_cnt_col;

endmodule

// File: tb/tb_memory_writer.sv
// Self-checking bench for memory_writer (4x3 frame): directed scenarios plus random traffic vs a frame-level model.
module tb_memory_writer;
  localparam int MR    = 4;
  localparam int MC    = 3;
  localparam int TOTAL = MR * MC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_i = '0;
  logic        data_en_i = 1'b0;
  logic        start_i = 1'b0;
  logic        ena_o, wea_o, busy_o, write_done_o, err_o;
  logic [18:0] addr_o;
  logic [7:0]  d2mem_o;
  logic [9:0]  cnt_img_row_o, cnt_img_col_o;
`ifdef MEMORY_WRITER_ROW_DONE_EN
  logic        row_done_o;
`endif

  always #5 clk = ~clk;

  memory_writer #(.MAX_ROW(MR), .MAX_COL(MC)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_i        (data_i),
    .data_en_i     (data_en_i),
    .start_i       (start_i),
    .ena_o         (ena_o),
    .wea_o         (wea_o),
    .addr_o        (addr_o),
    .d2mem_o       (d2mem_o),
    .busy_o        (busy_o),
    .write_done_o  (write_done_o),
    .err_o         (err_o),
    .cnt_img_row_o (cnt_img_row_o),
    .cnt_img_col_o (cnt_img_col_o)
`ifdef MEMORY_WRITER_ROW_DONE_EN
    ,
    .row_done_o    (row_done_o)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level model: mode 0=idle 1=writing 2=done, m_n = pixels written in this frame.
  int m_mode = 0;
  int m_n    = 0;
  int m_err  = 0;
  int e_ena = 0, e_data = 0, e_addr = 0, e_row = 0, e_col = 0, e_done = 0, e_rd = 0;
  int done_seen = 0, done_expected = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit en, input logic [7:0] d);
    rst = r; start_i = s; data_en_i = en; data_i = d;
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_n = 0; m_err = 0;
      e_ena = 0; e_data = 0; e_addr = 0; e_row = 0; e_col = 0; e_done = 0; e_rd = 0;
    end else begin
      e_ena = 0; e_data = 0; e_done = 0; e_rd = 0;
      case (m_mode)
        0: begin
          if (s) begin
            m_err = en; m_mode = 1; m_n = 0;
          end else if (en) m_err = 1;
        end
        1: begin
          if (en) begin
            e_ena  = 1;
            e_data = d;
            e_addr = m_n;
            e_row  = m_n / MC;
            e_col  = m_n % MC;
            e_rd   = (e_col == MC - 1);
            if (m_n == TOTAL - 1) begin
              e_done = 1; m_mode = 2;
            end
            m_n++;
          end
        end
        default: begin
          if (en) m_err = 1;
          m_mode = 0;
        end
      endcase
    end
    #1;
    done_expected += e_done;
    if (write_done_o === 1'b1) done_seen++;
    check("ena",   32'(ena_o),         32'(e_ena));
    check("wea",   32'(wea_o),         32'(e_ena));
    check("addr",  32'(addr_o),        32'(e_addr));
    check("data",  32'(d2mem_o),       32'(e_data));
    check("busy",  32'(busy_o),        32'(m_mode == 1));
    check("done",  32'(write_done_o),  32'(e_done));
    check("err",   32'(err_o),         32'(m_err));
    check("row",   32'(cnt_img_row_o), 32'(e_row));
    check("col",   32'(cnt_img_col_o), 32'(e_col));
`ifdef MEMORY_WRITER_ROW_DONE_EN
    check("row_done", 32'(row_done_o), 32'(e_rd));
`endif
  endtask

  task automatic frame(input bit gapped, input int start_at);
    int k;
    step(0, 1, 0, 8'h00);
    k = 0;
    while (k < TOTAL) begin
      if (gapped) step(0, 0, 0, 8'h55);
      step(0, (k == start_at), 1, 8'(8'h10 + k));
      k++;
    end
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
  endtask

  initial begin
    step(1, 0, 0, 8'h00);
    step(1, 1, 1, 8'hFF);
    step(0, 0, 0, 8'h00);

    frame(0, -1);                     // back-to-back full frame
    frame(1, -1);                     // data_en_i toggling every cycle

    step(0, 0, 1, 8'hAA);             // stray pixel in idle
    step(0, 0, 0, 8'h00);
    frame(0, -1);                     // start clears err

    step(0, 1, 0, 8'h00);             // abort after 5 pixels
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'h40 + i));
    step(1, 0, 0, 8'h00);
    frame(0, -1);

    frame(0, 6);                      // start during pixel 6 ignored

    step(0, 1, 1, 8'hC3);             // start with pixel: dropped, err set
    for (int i = 0; i < TOTAL; i++) step(0, 0, 1, 8'(i));
    step(0, 0, 1, 8'h77);             // stray pixel in done state
    step(0, 0, 0, 8'h00);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) != 0), 8'($urandom));
    end

    check("done_pulses", 32'(done_seen), 32'(done_expected));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_writer.md
MEMORY_WRITER -- requirements
Module: memory_writer

Interface
REQ-001 Parameters SHALL be:
- MAX_ROW, default 540, image rows.
- MAX_COL, default 540, image columns.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- data_i  in  8  processed pixel.
- data_en_i  in  1  pixel valid qualifier.
- start_i  in  1  frame start request from controller.
- ena_o  out  1  BRAM enable.
- wea_o  out  1  BRAM write enable.
- addr_o  out  19  BRAM address.
- d2mem_o  out  8  BRAM write data.
- busy_o  out  1  high in WRITE state.
- write_done_o  out  1  one-cycle frame-complete pulse.
- err_o  out  1  sticky: pixel arrived outside WRITE.
- cnt_img_row_o  out  10  row of the last written pixel.
- cnt_img_col_o  out  10  column of the last written pixel.

Function
REQ-003 The FSM SHALL have three states: IDLE, WRITE and DONE.
REQ-004 The FSM SHALL make these transitions:
- IDLE to WRITE on start_i.
- WRITE to DONE on acceptance of pixel MAX_ROW*MAX_COL-1.
- DONE to IDLE unconditionally after 1 cycle.
REQ-005 In WRITE, each cycle with data_en_i=1 SHALL accept data_i. One cycle later the block SHALL present ena_o=1, wea_o=1, d2mem_o=data_i and addr_o=the current write address.
REQ-006 In all other cycles ena_o, wea_o and d2mem_o SHALL be 0. addr_o SHALL hold its last value.
REQ-007 Write address handling:
- The address SHALL start at 0 on entry to WRITE.
- It SHALL increment by 1 per accepted pixel.
- It SHALL never exceed MAX_ROW*MAX_COL-1.
REQ-008 Column and row counters:
- The column counter SHALL wrap from MAX_COL-1 to 0.
- The row counter SHALL increment on each column wrap.
- The row counter SHALL wrap from MAX_ROW-1 to 0.
- cnt_img_row_o and cnt_img_col_o SHALL be aligned with addr_o, i.e. registered with the write strobe.
REQ-009 write_done_o SHALL be 1 in the cycle where the final pixel's write strobe is on the BRAM port. That is one cycle after the final data_en_i, coincident with the DONE state.
REQ-010 In WRITE, gaps in data_en_i SHALL stall the counters without error.
REQ-011 data_en_i=1 in IDLE or DONE SHALL be discarded (no write) and SHALL set err_o.
- err_o SHALL clear only on reset or on the next IDLE-to-WRITE transition.
REQ-012 start_i in WRITE or DONE SHALL be ignored.
REQ-013 start_i and data_en_i together in IDLE SHALL start the frame and discard that pixel, setting err_o. The pixel is not written.
REQ-014 busy_o SHALL equal (state==WRITE).
REQ-015 Address arithmetic SHALL be unsigned 19-bit. MAX_ROW*MAX_COL SHALL be <= 2^19, checked by an elaboration-time assertion.

Reset
REQ-016 While rst=1 at a clk edge, the block SHALL reset to:
- state IDLE;
- all counters 0;
- every output 0.
REQ-017 Reset asserted mid-frame SHALL abort the frame. No write_done_o pulse SHALL follow, and the next frame SHALL restart at address 0.

Configuration
REQ-018 With macro MEMORY_WRITER_ROW_DONE_EN defined, the block SHALL add output row_done_o (1 bit). It SHALL pulse for one cycle together with the write strobe of each pixel whose column is MAX_COL-1, including the final pixel.
REQ-019 Without MEMORY_WRITER_ROW_DONE_EN, the row_done_o port and its logic SHALL be absent. All other behaviour SHALL be identical.

Structure
REQ-020 A shared package SHALL hold:
- the FSM state enumeration (IDLE/WRITE/DONE);
- constants ADDR_W=19, PIX_W=8, CNT_W=10.
REQ-021 Row/column counting SHALL be one sub-module, img_pos_counter, with parameters MAX_ROW/MAX_COL and inputs clear and advance. memory_writer SHALL instantiate it once.

Verification (MAX_ROW=4, MAX_COL=3 unless noted)
REQ-022 Full frame: start_i, then 12 back-to-back pixels 0x10..0x1B -> writes to addr 0..11 with matching data, each one cycle after its input. write_done_o is high exactly once, with addr_o=11, row=3, col=2. busy_o then drops.
REQ-023 Gapped input: 12 pixels with data_en_i toggling every cycle -> same 12 writes, no err_o, write_done_o after the 12th.
REQ-024 Stray pixel: data_en_i=1 in IDLE with data 0xAA -> no write, err_o=1. A following start_i clears err_o.
REQ-025 Mid-frame reset: rst after 5 pixels, then start_i and 12 pixels -> first new write at addr 0, no done pulse from the aborted frame.
REQ-026 Start while busy: start_i pulsed during pixel 6 -> ignored; addresses continue 6..11.
REQ-027 With MEMORY_WRITER_ROW_DONE_EN: full frame -> row_done_o pulses at addr 2, 5, 8 and 11, and at no other address.
